aes_axi4_master_seq: RTL and testbench
======================================

Name: aes_axi4_master_seq

Overview:
- Synthesizable AXI4 (full) master that drives the AES256 AXI4 slave port (`s00_axi_*`) from a simple command/stream interface.
- Converts a command (read or write, start address, beat count) plus a write-data stream into compliant AW/W/B or AR/R transactions.
- Returns read data as a stream and reports completion status.
- Sits directly upstream of the AES256 slave IP; used by the on-chip controller and the system-level bench.

Parameters:
- ADDR_W, 6, AXI address width.
- DATA_W, 32, AXI data width (fixed 32; size field derived from it).
- ID_W, 2, AXI ID width.
- TXN_ID, 2'b11, ID driven on awid/arid and expected on bid/rid.
- WSTRB_VAL, 4'hF, constant write strobe for every beat.

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address (byte, word aligned)
- cmd_len  in  8  beats minus 1 (AXI len encoding)
- wr_data  in  DATA_W  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed
- rd_data  out  DATA_W  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  read beat consumed
- done  out  1  one-cycle pulse at transaction end
- status  out  2  captured bresp / worst rresp; forced 2'b10 on ID or last mismatch
- m00_axi_awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_W/8/3/2/ID_W/1  write address channel
- m00_axi_awready  in  1
- m00_axi_wdata/wstrb/wlast/wvalid  out  DATA_W/4/1/1  write data channel
- m00_axi_wready  in  1
- m00_axi_bresp/bid/bvalid  in  2/ID_W/1
- m00_axi_bready  out  1
- m00_axi_araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_W/8/3/2/ID_W/1
- m00_axi_arready  in  1
- m00_axi_rdata/rresp/rid/rlast/rvalid  in  DATA_W/2/ID_W/1/1
- m00_axi_rready  out  1

Behaviour:
- All state updates on posedge m00_axi_aclk.
- m00_axi_aresetn=0 sampled at an edge puts the block in IDLE on that edge and clears every output: all valids/readies 0, done 0, status 0, address/len/id registers 0. This holds mid-transaction too: the burst is abandoned and there is no completion pulse.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/len/write into registers and clear beat counter and status.
  - Go to AW if write, else AR.
- AW / AR:
  - awvalid (arvalid) is 1 from the cycle after acceptance.
  - awaddr/awlen/awid held stable until awready (arready) is sampled high.
  - awsize=3'b010, awburst=2'b01 (INCR); same for AR.
  - Then go to W or R.
  - No write data is presented before the AW handshake completes.
- W:
  - wvalid = wr_valid; wr_ready = wready. Both are combinational and gated by state W.
  - wdata = wr_data; wstrb = WSTRB_VAL.
  - wlast = (beat_cnt == len).
  - beat_cnt increments on each wvalid&wready.
  - The beat with wlast handshake moves to B. len=0 gives wlast on the first beat.
- B:
  - bready=1.
  - On bvalid, status = bresp, overridden to 2'b10 if bid != TXN_ID.
  - Go to DONE.
- R:
  - rready = rd_ready; rd_valid = rvalid; rd_data = rdata; rd_last = (beat_cnt == len).
  - Each handshake increments beat_cnt and folds rresp into status (max value kept).
  - On the beat with beat_cnt==len, status is forced 2'b10 if rlast=0 or rid != TXN_ID.
  - An rlast seen earlier than beat_cnt==len forces 2'b10 and ends the burst.
  - The final beat moves to DONE.
- DONE: done=1 for exactly one cycle, status stays valid until the next command is accepted, then return to IDLE.
- Latency, single write with zero-wait slave:
  - cmd accept at T0, awvalid at T1.
  - W beat handshake at T2, B handshake at T3, done at T4.
- Backpressure:
  - Any cycle with wr_valid=0 or wready=0 stalls W with no beat lost or duplicated.
  - rd_ready=0 holds rready low, so the slave holds the R beat.
- beat_cnt is 8 bits and never wraps; len=255 gives 256 beats.
- Address overflow past the 2^ADDR_W boundary is not checked; the slave owns decode errors.

Test Plan:
- Single write to addr 0x04, data 0xFFFFFFFF, len=0:
  - awaddr=0x04, awlen=0, awid=2'b11, one W beat with wlast=1, wstrb=4'hF.
  - bresp OKAY gives done pulse with status=2'b00.
- Burst write to addr 0x08, len=2, data 0xABABABAB/0xCDCDCDCD/0xEFEFEFEF, wr_valid dropped for 2 cycles mid-burst:
  - Exactly 3 W beats in order.
  - wlast only on 0xEFEFEFEF.
  - done after B.
- Read from addr 0x04, len=0, after the first test:
  - arburst=2'b01, rd_data=0xFFFFFFFF, rd_last=1, status=2'b00.
  - rd_ready held low 3 cycles first, so rready stays low during that time.
- Slave returns bresp=2'b10, and separately bid=2'b00: status=2'b10 in both cases; done still pulses once.
- Reset asserted during the second W beat of a len=3 burst:
  - Next edge: all valids 0, cmd_ready=1, no done pulse.
  - A following single write completes normally.
- Read len=3 with rlast asserted on beat 2: status=2'b10, done after beat 2, no further rready.

Source files
------------

// File: rtl/aes_axi4_master_seq.sv
// AXI4 burst master for the AES256 slave port: turns a command plus a write-data
// stream into AW/W/B or AR/R bursts and returns read beats and completion status.
module aes_axi4_master_seq #(
    parameter int unsigned         ADDR_W    = 6,
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         ID_W      = 2,
    parameter logic [ID_W-1:0]     TXN_ID    = 2'b11,
    parameter logic [DATA_W/8-1:0] WSTRB_VAL = 4'hF
) (
    input  logic                m00_axi_aclk,
    input  logic                m00_axi_aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    input  logic                rd_ready,
    output logic                done,
    output logic [1:0]          status,
    output logic [ADDR_W-1:0]   m00_axi_awaddr,
    output logic [7:0]          m00_axi_awlen,
    output logic [2:0]          m00_axi_awsize,
    output logic [1:0]          m00_axi_awburst,
    output logic [ID_W-1:0]     m00_axi_awid,
    output logic                m00_axi_awvalid,
    input  logic                m00_axi_awready,
    output logic [DATA_W-1:0]   m00_axi_wdata,
    output logic [DATA_W/8-1:0] m00_axi_wstrb,
    output logic                m00_axi_wlast,
    output logic                m00_axi_wvalid,
    input  logic                m00_axi_wready,
    input  logic [1:0]          m00_axi_bresp,
    input  logic [ID_W-1:0]     m00_axi_bid,
    input  logic                m00_axi_bvalid,
    output logic                m00_axi_bready,
    output logic [ADDR_W-1:0]   m00_axi_araddr,
    output logic [7:0]          m00_axi_arlen,
    output logic [2:0]          m00_axi_arsize,
    output logic [1:0]          m00_axi_arburst,
    output logic [ID_W-1:0]     m00_axi_arid,
    output logic                m00_axi_arvalid,
    input  logic                m00_axi_arready,
    input  logic [DATA_W-1:0]   m00_axi_rdata,
    input  logic [1:0]          m00_axi_rresp,
    input  logic [ID_W-1:0]     m00_axi_rid,
    input  logic                m00_axi_rlast,
    input  logic                m00_axi_rvalid,
    output logic                m00_axi_rready
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam logic [2:0]  AXI_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0]  AXI_INCR = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        beat_q;
    logic [1:0]        status_q;

    logic              in_w;
    logic              in_r;
    logic              last_beat;
    logic              w_fire;
    logic              r_fire;
    logic [7:0]        beat_d;
    logic [1:0]        status_max_d;

    assign in_w         = (state_q == S_W);
    assign in_r         = (state_q == S_R);
    assign last_beat    = (beat_q == len_q);
    assign w_fire       = in_w & wr_valid & m00_axi_wready;
    assign r_fire       = in_r & m00_axi_rvalid & rd_ready;
    assign beat_d       = beat_q + 8'd1;
    assign status_max_d = (m00_axi_rresp > status_q) ? m00_axi_rresp : status_q;

    // Control FSM; beat counter only matters inside a burst so it never needs to wrap.
    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_q   <= '0;
            status_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    addr_q   <= cmd_addr;
                    len_q    <= cmd_len;
                    id_q     <= TXN_ID;
                    beat_q   <= '0;
                    status_q <= '0;
                    state_q  <= cmd_write ? S_AW : S_AR;
                end
                S_AW: if (m00_axi_awready) state_q <= S_W;
                S_AR: if (m00_axi_arready) state_q <= S_R;
                S_W: if (w_fire) begin
                    beat_q <= beat_d;
                    if (last_beat) state_q <= S_B;
                end
                S_B: if (m00_axi_bvalid) begin
                    status_q <= (m00_axi_bid != TXN_ID) ? RESP_SLVERR : m00_axi_bresp;
                    state_q  <= S_DONE;
                end
                S_R: if (r_fire) begin
                    beat_q <= beat_d;
                    if (last_beat) begin
                        status_q <= (!m00_axi_rlast || m00_axi_rid != TXN_ID) ? RESP_SLVERR
                                                                             : status_max_d;
                        state_q  <= S_DONE;
                    end else if (m00_axi_rlast) begin
                        status_q <= RESP_SLVERR;
                        state_q  <= S_DONE;
                    end else begin
                        status_q <= status_max_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Channel valids/readies decode straight from the state register.
    assign cmd_ready       = (state_q == S_IDLE);
    assign done            = (state_q == S_DONE);
    assign status          = status_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awlen   = len_q;
    assign m00_axi_awsize  = AXI_SIZE;
    assign m00_axi_awburst = AXI_INCR;
    assign m00_axi_awid    = id_q;
    assign m00_axi_awvalid = (state_q == S_AW);

    assign m00_axi_wdata   = wr_data;
    assign m00_axi_wstrb   = WSTRB_VAL;
    assign m00_axi_wlast   = in_w & last_beat;
    assign m00_axi_wvalid  = in_w & wr_valid;
    assign wr_ready        = in_w & m00_axi_wready;
    assign m00_axi_bready  = (state_q == S_B);

    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arsize  = AXI_SIZE;
    assign m00_axi_arburst = AXI_INCR;
    assign m00_axi_arid    = id_q;
    assign m00_axi_arvalid = (state_q == S_AR);

    assign m00_axi_rready  = in_r & rd_ready;
    assign rd_valid        = in_r & m00_axi_rvalid;
    assign rd_data         = m00_axi_rdata;
    assign rd_last         = in_r & last_beat;
endmodule

// File: tb/tb_aes_axi4_master_seq.sv
// Bench for aes_axi4_master_seq: table vectors, hand-built corner sequences and
// random bursts against a word-memory slave model and rule-based status model.
module tb_aes_axi4_master_seq;
    localparam logic [1:0] TXN = 2'b11;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready, done;
    logic [1:0]  status;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, awid, arid;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, bid, rresp, rid;
    logic        bvalid, bready, rlast, rvalid, rready;

    aes_axi4_master_seq dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .status(status),
        .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
        .m00_axi_awburst(awburst), .m00_axi_awid(awid), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bid(bid), .m00_axi_bvalid(bvalid),
        .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
        .m00_axi_arburst(arburst), .m00_axi_arid(arid), .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rid(rid),
        .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cyc;
    logic [31:0] last_rd;
    logic [31:0] mem [16];
    logic [31:0] wq [$];
    logic [1:0]  rr [$];

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [7:0]  len;
        logic [1:0]  resp;
        bit          bad_id;
        logic [31:0] d0;
        int          drop_at;
        int          hold;
        int          pct;
        logic [1:0]  exp_st;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [5:0] a, input int k);
        return (int'(a[5:2]) + k) % 16;
    endfunction

    function automatic bit coin(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = '0; bid = '0;
        rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 0;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [7:0] len,
                            input logic [1:0] bresp_v, input logic [1:0] bid_v,
                            input int drop_at, input int pct,
                            output logic [1:0] st, output int beats);
        int n, idx, drops, cyc;
        bit aw_hs, b_hs, bv, fin, done_due;
        n = int'(len) + 1; idx = 0; drops = 0; cyc = 0;
        aw_hs = 0; b_hs = 0; bv = 0; fin = 0; done_due = 0; st = 2'bxx; done_cyc = -1;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
        #1 chk("w_cmd_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 0;
        while (!fin && cyc < 3000) begin
            awready = coin(pct);
            wready  = coin(pct);
            if (aw_hs && idx < n) begin
                if (idx == drop_at && drops < 2) begin
                    wr_valid = 0;
                    drops++;
                end else begin
                    wr_valid = coin(pct);
                end
                wr_data = wq[idx];
            end else begin
                wr_valid = 1'($urandom_range(1));
                wr_data  = $urandom;
            end
            if (idx == n && !b_hs && !bv) bv = coin(pct);
            bvalid = bv; bresp = bresp_v; bid = bid_v;
            #1;
            chk("w_cmd_ready_busy", 32'(cmd_ready), 32'(0));
            chk("awvalid", 32'(awvalid), 32'(!aw_hs));
            chk("wvalid", 32'(wvalid), 32'(aw_hs && idx < n && wr_valid));
            chk("wr_ready", 32'(wr_ready), 32'(aw_hs && idx < n && wready));
            chk("bready", 32'(bready), 32'(idx == n && !b_hs));
            chk("w_done", 32'(done), 32'(done_due));
            if (done_due) begin
                st = status; fin = 1; done_cyc = cyc;
            end
            done_due = 0;
            if (!aw_hs && awready) begin
                chk("awaddr", 32'(awaddr), 32'(addr));
                chk("awlen", 32'(awlen), 32'(len));
                chk("awid", 32'(awid), 32'(TXN));
                chk("awsize", 32'(awsize), 32'(3'b010));
                chk("awburst", 32'(awburst), 32'(2'b01));
                aw_hs = 1;
            end else if (aw_hs && idx < n && wr_valid && wready) begin
                chk("wdata", wdata, wq[idx]);
                chk("wlast", 32'(wlast), 32'(idx == n - 1));
                chk("wstrb", 32'(wstrb), 32'(4'hF));
                mem[widx(addr, idx)] = wq[idx];
                idx++;
            end else if (idx == n && bv && !b_hs) begin
                b_hs = 1; bv = 0; done_due = 1;
            end
            cyc++;
            @(negedge clk);
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL w_timeout: beats %0d of %0d, no done", idx, n);
        end
        idle_inputs();
        #1;
        chk("w_done_single", 32'(done), 32'(0));
        chk("w_cmd_ready_after", 32'(cmd_ready), 32'(1));
        chk("w_status_hold", 32'(status), 32'(st));
        beats = idx;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [7:0] len,
                           input int early, input bit bad_rid, input int hold, input int pct,
                           output logic [1:0] st, output int beats);
        int n, nb, k, holds, cyc;
        bit ar_hs, rv, fin, done_due;
        n = int'(len) + 1; nb = (early >= 0) ? early + 1 : n;
        k = 0; holds = 0; cyc = 0; ar_hs = 0; rv = 0; fin = 0; done_due = 0; st = 2'bxx;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
        #1 chk("r_cmd_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 0;
        while (!fin && cyc < 3000) begin
            arready = coin(pct);
            if (ar_hs && k < nb) begin
                if (holds < hold) begin
                    rd_ready = 0; rv = 1; holds++;
                end else begin
                    if (!rv) rv = coin(pct);
                    rd_ready = coin(pct);
                end
            end else begin
                rd_ready = 1'($urandom_range(1));
            end
            rvalid = rv;
            rdata  = mem[widx(addr, k)];
            rresp  = (k < nb) ? rr[k] : 2'b00;
            rid    = (bad_rid && k == nb - 1) ? 2'b00 : TXN;
            rlast  = (k == nb - 1);
            #1;
            chk("r_cmd_ready_busy", 32'(cmd_ready), 32'(0));
            chk("arvalid", 32'(arvalid), 32'(!ar_hs));
            chk("rready", 32'(rready), 32'(ar_hs && k < nb && rd_ready));
            chk("rd_valid", 32'(rd_valid), 32'(ar_hs && k < nb && rv));
            chk("r_done", 32'(done), 32'(done_due));
            if (done_due) begin
                st = status; fin = 1;
            end
            done_due = 0;
            if (!ar_hs && arready) begin
                chk("araddr", 32'(araddr), 32'(addr));
                chk("arlen", 32'(arlen), 32'(len));
                chk("arid", 32'(arid), 32'(TXN));
                chk("arsize", 32'(arsize), 32'(3'b010));
                chk("arburst", 32'(arburst), 32'(2'b01));
                ar_hs = 1;
            end else if (ar_hs && k < nb && rv && rd_ready) begin
                chk("rd_data", rd_data, mem[widx(addr, k)]);
                chk("rd_last", 32'(rd_last), 32'(k == n - 1));
                last_rd = rd_data;
                k++; rv = 0;
                if (k == nb) done_due = 1;
            end
            cyc++;
            @(negedge clk);
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL r_timeout: beats %0d of %0d, no done", k, nb);
        end
        for (int c = 0; c < 3; c++) begin
            rvalid = 1; rd_ready = 1; rlast = 1'($urandom_range(1));
            #1;
            chk("r_no_rready_after", 32'(rready), 32'(0));
            chk("r_done_single", 32'(done), 32'(0));
            chk("r_status_hold", 32'(status), 32'(st));
            @(negedge clk);
        end
        idle_inputs();
        beats = k;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st, exp_st, wbid, m;
        int beats, n, early;
        bit bad;
        logic [5:0] a;
        logic [7:0] l;

        vecs[0]  = '{1, 6'h04, 8'd0,   2'b00, 0, 32'hFFFFFFFF, -1, 0, 100, 2'b00};
        vecs[1]  = '{1, 6'h08, 8'd2,   2'b00, 0, 32'hABABABAB,  1, 0, 100, 2'b00};
        vecs[2]  = '{0, 6'h04, 8'd0,   2'b00, 0, 32'h0,        -1, 3, 100, 2'b00};
        vecs[3]  = '{1, 6'h10, 8'd0,   2'b10, 0, 32'h11110000, -1, 0,  70, 2'b10};
        vecs[4]  = '{1, 6'h14, 8'd1,   2'b00, 1, 32'h22220000, -1, 0,  70, 2'b10};
        vecs[5]  = '{0, 6'h08, 8'd2,   2'b00, 0, 32'h0,        -1, 0,  60, 2'b00};
        vecs[6]  = '{0, 6'h08, 8'd2,   2'b01, 0, 32'h0,        -1, 1,  80, 2'b01};
        vecs[7]  = '{0, 6'h00, 8'd0,   2'b00, 1, 32'h0,        -1, 0, 100, 2'b10};
        vecs[8]  = '{0, 6'h0C, 8'd0,   2'b11, 0, 32'h0,        -1, 0, 100, 2'b11};
        vecs[9]  = '{1, 6'h00, 8'd255, 2'b00, 0, 32'h01000000, -1, 0,  90, 2'b00};
        vecs[10] = '{0, 6'h00, 8'd255, 2'b00, 0, 32'h0,        -1, 0,  90, 2'b00};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        idle_inputs();
        rstn = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_awvalid", 32'(awvalid), 32'(0));
        chk("rst_arvalid", 32'(arvalid), 32'(0));
        chk("rst_bready", 32'(bready), 32'(0));
        chk("rst_rready", 32'(rready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_status", 32'(status), 32'(0));
        chk("rst_awaddr", 32'(awaddr), 32'(0));
        chk("rst_awlen", 32'(awlen), 32'(0));
        chk("rst_awid", 32'(awid), 32'(0));
        rstn = 1;

        for (int i = 0; i < 11; i++) begin
            n = int'(vecs[i].len) + 1;
            if (vecs[i].wr) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back(vecs[i].d0 + 32'(k) * 32'h22222222);
                wbid = vecs[i].bad_id ? 2'b00 : TXN;
                do_write(vecs[i].addr, vecs[i].len, vecs[i].resp, wbid,
                         vecs[i].drop_at, vecs[i].pct, st, beats);
                if (i == 0) chk("w_latency", 32'(done_cyc), 32'(3));
            end else begin
                rr.delete();
                for (int k = 0; k < n; k++) rr.push_back(vecs[i].resp);
                do_read(vecs[i].addr, vecs[i].len, -1, vecs[i].bad_id,
                        vecs[i].hold, vecs[i].pct, st, beats);
                if (i == 2) chk("rd_addr04", last_rd, 32'hFFFFFFFF);
            end
            chk($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].exp_st));
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(n));
        end

        // Early rlast on beat 2 of a 4-beat read.
        rr.delete();
        for (int k = 0; k < 4; k++) rr.push_back(2'b00);
        do_read(6'h08, 8'd3, 2, 0, 0, 100, st, beats);
        chk("early_status", 32'(st), 32'(2'b10));
        chk("early_beats", 32'(beats), 32'(3));

        // Reset lands while the second W beat of a 4-beat write is on the bus.
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back($urandom);
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h20; cmd_len = 8'd3;
        awready = 1; wready = 1; wr_valid = 1; wr_data = wq[0];
        @(negedge clk);
        cmd_valid = 0;
        #1 chk("rstw_awvalid", 32'(awvalid), 32'(1));
        @(negedge clk);
        #1 chk("rstw_beat0", 32'(wvalid), 32'(1));
        mem[widx(6'h20, 0)] = wq[0];
        @(negedge clk);
        wr_data = wq[1]; rstn = 0;
        #1 chk("rstw_beat1", 32'(wvalid), 32'(1));
        @(posedge clk);
        #1;
        chk("rstw_awvalid_clr", 32'(awvalid), 32'(0));
        chk("rstw_wvalid_clr", 32'(wvalid), 32'(0));
        chk("rstw_bready_clr", 32'(bready), 32'(0));
        chk("rstw_arvalid_clr", 32'(arvalid), 32'(0));
        chk("rstw_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rstw_done", 32'(done), 32'(0));
        chk("rstw_status", 32'(status), 32'(0));
        @(negedge clk);
        rstn = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("rstw_no_done", 32'(done), 32'(0));
            chk("rstw_no_wvalid", 32'(wvalid), 32'(0));
        end
        idle_inputs();
        wq.delete();
        wq.push_back(32'h5A5A0001);
        do_write(6'h24, 8'd0, 2'b00, TXN, -1, 100, st, beats);
        chk("rstw_after_status", 32'(st), 32'(0));
        chk("rstw_after_beats", 32'(beats), 32'(1));

        // Random bursts against the rule-based status model.
        for (int t = 0; t < 24; t++) begin
            a = {4'($urandom_range(15)), 2'b00};
            l = 8'($urandom_range(7));
            n = int'(l) + 1;
            if ($urandom_range(1) == 1) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back($urandom);
                bresp = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
                wbid  = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : TXN;
                exp_st = (wbid != TXN) ? 2'b10 : bresp;
                do_write(a, l, bresp, wbid, -1, int'($urandom_range(40, 100)), st, beats);
                chk("rand_w_status", 32'(st), 32'(exp_st));
                chk("rand_w_beats", 32'(beats), 32'(n));
            end else begin
                rr.delete();
                for (int k = 0; k < n; k++)
                    rr.push_back(($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00);
                bad   = ($urandom_range(4) == 0);
                early = (n > 1 && $urandom_range(3) == 0) ? int'($urandom_range(n - 2)) : -1;
                m = 2'b00;
                for (int k = 0; k < ((early >= 0) ? early + 1 : n); k++)
                    if (rr[k] > m) m = rr[k];
                exp_st = (early >= 0 || bad) ? 2'b10 : m;
                do_read(a, l, early, bad, int'($urandom_range(2)),
                        int'($urandom_range(40, 100)), st, beats);
                chk("rand_r_status", 32'(st), 32'(exp_st));
                chk("rand_r_beats", 32'(beats), 32'((early >= 0) ? early + 1 : n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
